// File: rtl/pc_pkg.sv
// Shared types for the program-counter unit: FSM states and next-PC select codes.
package pc_pkg;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } pc_state_e;

    typedef enum logic [2:0] {
        SEL_SEQ  = 3'd0,
        SEL_BR   = 3'd1,
        SEL_JMP  = 3'd2,
        SEL_CALL = 3'd3,
        SEL_RET  = 3'd4,
        SEL_EXC  = 3'd5
    } pc_sel_e;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack: overflow overwrites the oldest entry,
// underflow leaves the stack as it is; both raise a one-cycle err pulse.
module pc_ras #(
    parameter int WIDTH     = 32,
    parameter int RAS_DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] top,
    output logic             empty,
    output logic             full,
    output logic             err
);

    localparam int PW = $clog2(RAS_DEPTH);

    logic [WIDTH-1:0] mem [RAS_DEPTH];
    logic [PW-1:0]    ptr;
    logic [PW:0]      count;
    logic [PW-1:0]    top_idx;

    // ptr is the next free slot, so the top sits one below it (mod depth).
    assign top_idx = ptr - 1'b1;
    assign empty   = (count == '0);
    assign full    = (count == (PW+1)'(RAS_DEPTH));
    assign top     = empty ? '0 : mem[top_idx];

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr   <= '0;
            count <= '0;
            err   <= 1'b0;
        end else begin
            err <= 1'b0;
            if (push && pop) begin
                if (empty) begin
                    mem[ptr] <= push_data;
                    ptr      <= ptr + 1'b1;
                    count    <= count + 1'b1;
                end else begin
                    mem[top_idx] <= push_data;
                end
            end else if (push) begin
                mem[ptr] <= push_data;
                ptr      <= ptr + 1'b1;
                if (full) begin
                    err <= 1'b1;
                end else begin
                    count <= count + 1'b1;
                end
            end else if (pop) begin
                if (empty) begin
                    err <= 1'b1;
                end else begin
                    ptr   <= ptr - 1'b1;
                    count <= count - 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/pc_unit.sv
// Program-counter register with prioritised next-PC selection, halt/resume FSM,
// target alignment check and a return-address stack for call/ret.
module pc_unit
    import pc_pkg::*;
#(
    parameter int               WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [WIDTH-1:0] EXC_VECTOR   = 32'h8000_0180,
    parameter int               INC          = 4,
    parameter int               RAS_DEPTH    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             halt,
    input  logic             resume,
    input  logic             exc,
    input  logic             branch_taken,
    input  logic [WIDTH-1:0] branch_target,
    input  logic             jump,
    input  logic             call,
    input  logic             ret,
    input  logic [WIDTH-1:0] jump_target,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus_inc,
    output logic [WIDTH-1:0] ras_top,
    output logic             ras_empty,
    output logic             ras_full,
    output logic             ras_err,
    output logic             misalign,
    output logic             halted
);

    localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'(INC - 1);

    pc_state_e        state;
    pc_sel_e          sel;
    logic [WIDTH-1:0] target;
    logic             target_bad;
    logic             advance;
    logic             ras_push;
    logic             ras_pop;

    assign pc_plus_inc = pc + WIDTH'(INC);
    assign halted      = (state == HALTED);

    always_comb begin
        sel    = SEL_SEQ;
        target = pc_plus_inc;
        if (exc) begin
            sel    = SEL_EXC;
            target = EXC_VECTOR;
        end else if (ret) begin
            // call+ret replaces the top entry and always goes to jump_target
            sel    = SEL_RET;
            target = (call || ras_empty) ? jump_target : ras_top;
        end else if (call) begin
            sel    = SEL_CALL;
            target = jump_target;
        end else if (jump) begin
            sel    = SEL_JMP;
            target = jump_target;
        end else if (branch_taken) begin
            sel    = SEL_BR;
            target = branch_target;
        end
    end

    assign target_bad = (sel != SEL_EXC) && ((target & ALIGN_MASK) != '0);
    assign advance    = !exc && !stall && (state == RUN) && !halt;
    assign ras_push   = advance && !target_bad && call;
    assign ras_pop    = advance && !target_bad && ret;

    always_ff @(posedge clk) begin
        if (reset) begin
            pc       <= RESET_VECTOR;
            state    <= RUN;
            misalign <= 1'b0;
        end else begin
            misalign <= 1'b0;
            if (exc) begin
                pc    <= EXC_VECTOR;
                state <= RUN;
            end else if (!stall) begin
                case (state)
                    RUN: begin
                        if (halt) begin
                            state <= HALTED;
                        end else begin
                            pc       <= target_bad ? EXC_VECTOR : target;
                            misalign <= target_bad;
                        end
                    end
                    HALTED: begin
                        if (resume) state <= RUN;
                    end
                    default: state <= RUN;
                endcase
            end
        end
    end

    pc_ras #(
        .WIDTH    (WIDTH),
        .RAS_DEPTH(RAS_DEPTH)
    ) u_ras (
        .clk      (clk),
        .reset    (reset),
        .push     (ras_push),
        .pop      (ras_pop),
        .push_data(pc_plus_inc),
        .top      (ras_top),
        .empty    (ras_empty),
        .full     (ras_full),
        .err      (ras_err)
    );

endmodule

// File: tb/tb_pc_unit.sv
// Directed-vector bench for pc_unit: sequencing, redirects, RAS, stall, halt, exceptions.
module tb_pc_unit;

    localparam logic [31:0] EXC = 32'h8000_0180;

    logic        clk = 1'b0;
    logic        reset, stall, halt, resume, exc;
    logic        branch_taken, jump, call, ret;
    logic [31:0] branch_target, jump_target;
    logic [31:0] pc, pc_plus_inc, ras_top;
    logic        ras_empty, ras_full, ras_err, misalign, halted;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pc_unit dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .halt         (halt),
        .resume       (resume),
        .exc          (exc),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .jump         (jump),
        .call         (call),
        .ret          (ret),
        .jump_target  (jump_target),
        .pc           (pc),
        .pc_plus_inc  (pc_plus_inc),
        .ras_top      (ras_top),
        .ras_empty    (ras_empty),
        .ras_full     (ras_full),
        .ras_err      (ras_err),
        .misalign     (misalign),
        .halted       (halted)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One rising edge, then settle so outputs are sampled away from the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        reset = 0; stall = 0; halt = 0; resume = 0; exc = 0;
        branch_taken = 0; jump = 0; call = 0; ret = 0;
    endtask

    logic [31:0] ret_addrs [4] = '{32'h404, 32'h304, 32'h204, 32'h104};

    initial begin
        idle();
        branch_target = '0;
        jump_target   = '0;

        // reset and free-running sequence
        reset = 1; step();
        check("reset_pc", pc, 32'h0);
        check("reset_empty", {31'b0, ras_empty}, 32'h1);
        check("reset_err", {30'b0, ras_err, misalign}, 32'h0);
        check("reset_halted", {31'b0, halted}, 32'h0);
        reset = 0;
        step(); check("seq_4", pc, 32'h4);
        step(); check("seq_8", pc, 32'h8);
        step(); check("seq_c", pc, 32'hc);
        step(); check("seq_10", pc, 32'h10);

        // branch, then misaligned jump
        branch_taken = 1; branch_target = 32'h40; step();
        check("branch", pc, 32'h40);
        branch_taken = 0; jump = 1; jump_target = 32'h43; step();
        check("misalign_pc", pc, EXC);
        check("misalign_flag", {31'b0, misalign}, 32'h1);
        jump = 0; step();
        check("misalign_pulse", {31'b0, misalign}, 32'h0);
        check("after_exc_seq", pc, EXC + 32'h4);

        // five nested calls overflow the 4-entry RAS
        jump = 1; jump_target = 32'h20; step();
        check("jump_20", pc, 32'h20);
        jump = 0; call = 1;
        for (int i = 1; i <= 5; i++) begin
            jump_target = 32'h100 * i;
            step();
            check($sformatf("call%0d_pc", i), pc, 32'h100 * i);
            check($sformatf("call%0d_err", i), {31'b0, ras_err}, (i == 5) ? 32'h1 : 32'h0);
        end
        check("ovf_full", {31'b0, ras_full}, 32'h1);
        check("ovf_top", ras_top, 32'h404);
        call = 0; ret = 1;
        for (int i = 0; i < 4; i++) begin
            step();
            check($sformatf("ret%0d_pc", i + 1), pc, ret_addrs[i]);
            check($sformatf("ret%0d_err", i + 1), {31'b0, ras_err}, 32'h0);
        end
        check("ret_empty", {31'b0, ras_empty}, 32'h1);
        jump_target = 32'h600; step();
        check("underflow_pc", pc, 32'h600);
        check("underflow_err", {31'b0, ras_err}, 32'h1);

        // call then call+ret: top replaced, count unchanged
        ret = 0; call = 1; jump_target = 32'h700; step();
        check("call_700", pc, 32'h700);
        check("err_cleared", {31'b0, ras_err}, 32'h0);
        check("top_604", ras_top, 32'h604);
        ret = 1; jump_target = 32'h800; step();
        check("callret_pc", pc, 32'h800);
        check("callret_top", ras_top, 32'h704);
        check("callret_flags", {29'b0, ras_err, ras_empty, ras_full}, 32'h0);

        // stall holds pc and RAS with a pending branch
        call = 0; ret = 0; stall = 1; branch_taken = 1; branch_target = 32'h900;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_pc", pc, 32'h800);
            check("stall_top", ras_top, 32'h704);
        end
        stall = 0; step();
        check("unstall_branch", pc, 32'h900);

        // halt / resume
        branch_taken = 0; jump = 1; jump_target = 32'h50; step();
        check("jump_50", pc, 32'h50);
        jump = 0; halt = 1; step();
        check("halted", {31'b0, halted}, 32'h1);
        check("halt_pc", pc, 32'h50);
        halt = 0; jump = 1; jump_target = 32'h1000;
        for (int i = 0; i < 3; i++) begin
            step();
            check("halt_hold", pc, 32'h50);
        end
        jump = 0; resume = 1; step();
        check("resume_halted", {31'b0, halted}, 32'h0);
        check("resume_pc", pc, 32'h50);
        resume = 0; step();
        check("resume_next", pc, 32'h54);

        // exception while halted
        halt = 1; step();
        check("halt2", {31'b0, halted}, 32'h1);
        halt = 0; exc = 1; step();
        check("exc_pc", pc, EXC);
        check("exc_halted", {31'b0, halted}, 32'h0);
        exc = 0; step();
        check("exc_next", pc, EXC + 32'h4);

        // sequential wrap
        jump = 1; jump_target = 32'hffff_fffc; step();
        check("wrap_plus", pc_plus_inc, 32'h0);
        jump = 0; step();
        check("wrap_pc", pc, 32'h0);
        check("wrap_flag", {31'b0, misalign}, 32'h0);

        // reset in the middle of a call
        check("pre_reset_nonempty", {31'b0, ras_empty}, 32'h0);
        call = 1; jump_target = 32'h100; reset = 1; step();
        check("rst_call_pc", pc, 32'h0);
        check("rst_call_empty", {31'b0, ras_empty}, 32'h1);
        check("rst_call_top", ras_top, 32'h0);

        // misaligned call does not push
        reset = 0; jump_target = 32'h102; step();
        check("mis_call_pc", pc, EXC);
        check("mis_call_flag", {31'b0, misalign}, 32'h1);
        check("mis_call_empty", {31'b0, ras_empty}, 32'h1);
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
